// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32 instruction-fetch stage owning the PC, a one-outstanding imem request FSM
// and the IF/ID register. Define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_kill_cnt outputs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] ID_pc,
  output logic [31:0] instr,
  output logic        instr_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_im_req;
  logic [31:0] r_im_addr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;
  logic        w_if_wr;
  logic        w_discard;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4    = r_im_addr + 32'd4;

  // A real instruction reaches IF/ID either straight from memory or from the hold buffer.
  assign w_if_wr = !redirect && !stall &&
                   (((r_state == S_WAIT) && im_rvalid) || (r_state == S_HOLD));

  // Responses that never reach IF/ID: killed fetches and a flushed hold buffer.
  assign w_discard = (((r_state == S_WAIT) && im_rvalid && redirect) ||
                      ((r_state == S_DROP) && im_rvalid) ||
                      ((r_state == S_HOLD) && redirect));

  assign im_req      = r_im_req;
  assign im_addr     = r_im_addr;
  assign ID_pc       = r_id_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

  // Fetch FSM, PC, hold buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_kill        <= 1'b0;
      r_im_req      <= 1'b0;
      r_im_addr     <= RESET_PC;
      r_hold_pc     <= 32'h0000_0000;
      r_hold_instr  <= 32'h0000_0000;
      r_id_pc       <= 32'h0000_0000;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
    end else begin
      if (redirect) begin
        r_pc          <= w_redirect_pc;
        r_id_pc       <= 32'h0000_0000;
        r_instr       <= NOP_INSTR;
        r_instr_valid <= 1'b0;
      end else if (w_if_wr) begin
        r_id_pc       <= (r_state == S_HOLD) ? r_hold_pc : r_im_addr;
        r_instr       <= (r_state == S_HOLD) ? r_hold_instr : im_rdata;
        r_instr_valid <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_state   <= S_REQ;
          r_im_req  <= 1'b1;
          r_im_addr <= redirect ? w_redirect_pc : r_pc;
        end
        S_REQ: begin
          // The address is already on the bus, so a redirect only marks the fetch as killed.
          if (im_gnt) begin
            r_im_req <= 1'b0;
            r_state  <= (redirect || r_kill) ? S_DROP : S_WAIT;
          end else if (redirect) begin
            r_kill <= 1'b1;
          end
        end
        S_WAIT: begin
          if (im_rvalid) begin
            if (redirect) begin
              r_state   <= S_REQ;
              r_im_req  <= 1'b1;
              r_im_addr <= w_redirect_pc;
            end else if (stall) begin
              r_hold_pc    <= r_im_addr;
              r_hold_instr <= im_rdata;
              r_pc         <= w_pc_plus4;
              r_state      <= S_HOLD;
            end else begin
              r_pc      <= w_pc_plus4;
              r_im_addr <= w_pc_plus4;
              r_im_req  <= 1'b1;
              r_state   <= S_REQ;
            end
          end else if (redirect) begin
            r_state <= S_DROP;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_state   <= S_REQ;
            r_im_req  <= 1'b1;
            r_im_addr <= w_redirect_pc;
          end else if (!stall) begin
            r_state   <= S_REQ;
            r_im_req  <= 1'b1;
            r_im_addr <= r_pc;
          end
        end
        S_DROP: begin
          if (im_rvalid) begin
            r_kill    <= 1'b0;
            r_state   <= S_REQ;
            r_im_req  <= 1'b1;
            r_im_addr <= redirect ? w_redirect_pc : r_pc;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_im_req <= 1'b0;
          r_kill   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_kill_cnt;

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_kill_cnt  = r_perf_kill_cnt;

  // Event counters: valid IF/ID writes and discarded responses, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch_cnt <= 32'h0000_0000;
      r_perf_kill_cnt  <= 32'h0000_0000;
    end else begin
      if (w_if_wr) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (w_discard) begin
        r_perf_kill_cnt <= r_perf_kill_cnt + 32'd1;
      end
    end
  end
`else
  logic w_unused_discard;
  assign w_unused_discard = w_discard;
`endif

endmodule
